// File: rtl/loader_pkg.sv
// Shared types and constants for the serial RAM loader.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned ADDR_FIELD_W = 16;
  localparam int unsigned CNT_FIELD_W  = 16;

  localparam logic [BYTE_W-1:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO
`ifdef LOADER_CHECKSUM_EN
    ,
    CHECK
`endif
  } state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream in from the host link and write port b out to the RAM.
// The master modport is the loader side.
interface ram_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output ram_address,
    output ram_wdata,
    output ram_we
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  ram_address,
    input  ram_wdata,
    input  ram_we
  );

endinterface

// File: rtl/ram_loader.sv
// Frame parser that writes a host-supplied image into RAM port b while holding the CPU.
// Define LOADER_CHECKSUM_EN to require and verify an XOR checksum byte after the data.
module ram_loader
  import loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned RAM_REGISTER_COUNT = 1024
) (
  input  logic          CLK_50,
  input  logic          reset,
  ram_loader_if.master  bus,
  output logic          hold_cpu,
  output logic          done,
  output logic          error
);

  localparam int unsigned ADDR_W = $clog2(RAM_REGISTER_COUNT);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [CNT_FIELD_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0]       hi_q, hi_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]       csum_q, csum_d;
`endif

  logic                    rx_ready_c;
  logic                    xfer_c;
  logic                    err_set_c;
  logic [ADDR_FIELD_W-1:0] addr_full_c;
  logic [CNT_FIELD_W-1:0]  cnt_full_c;
  logic [ADDR_W-1:0]       ptr_inc_c;

  // Never back-pressures; only reset blocks the link.
  assign rx_ready_c  = ~reset;
  assign xfer_c      = bus.rx_valid & rx_ready_c;
  assign addr_full_c = {hi_q, bus.rx_data};
  assign cnt_full_c  = {cnt_q[CNT_FIELD_W-1:BYTE_W], bus.rx_data};
  assign ptr_inc_c   = (ptr_q == ADDR_W'(RAM_REGISTER_COUNT - 1)) ? '0 : ptr_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    err_set_c = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (xfer_c) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == LOADER_SYNC) begin
            state_d = ADDR_HI;
            err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
        ADDR_HI: begin
          hi_d    = bus.rx_data;
          state_d = ADDR_LO;
        end
        ADDR_LO: begin
          ptr_d   = ADDR_W'(addr_full_c);
          state_d = CNT_HI;
        end
        CNT_HI: begin
          cnt_d   = {bus.rx_data, BYTE_W'(0)};
          state_d = CNT_LO;
        end
        CNT_LO: begin
          cnt_d = cnt_full_c;
          if (cnt_full_c == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA_HI;
          end
        end
        DATA_HI: begin
          hi_d    = bus.rx_data;
          state_d = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
        end
        DATA_LO: begin
          // Write strobe, address and data all land one cycle after this byte.
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = DATA_WIDTH'({hi_q, bus.rx_data});
          ptr_d   = ptr_inc_c;
          cnt_d   = cnt_q - CNT_FIELD_W'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_data;
`endif
          if (cnt_q == CNT_FIELD_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = DATA_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          state_d = IDLE;
          if (bus.rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d     = 1'b1;
            err_set_c = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    // Hold stays up through the cycle that reports the frame outcome.
    hold_d = (state_d != IDLE) | done_d | err_set_c;
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.rx_ready    = rx_ready_c;
  assign bus.ram_address = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.ram_we      = we_q;
  assign hold_cpu        = hold_q;
  assign done            = done_q;
  assign error           = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed frame tests for ram_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_ram_loader;

  logic CLK_50;
  logic reset;
  logic hold_cpu, done, error;

  ram_loader_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  ram_loader #(.DATA_WIDTH(16), .RAM_REGISTER_COUNT(1024)) dut (
    .CLK_50   (CLK_50),
    .reset    (reset),
    .bus      (bus),
    .hold_cpu (hold_cpu),
    .done     (done),
    .error    (error)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic [7:0]  frame[$];
  int          done_cnt    = 0;
  int          overlap_cnt = 0;

  // Log writes and pulses mid-cycle, away from the active edge.
  always @(negedge CLK_50) begin
    if (bus.ram_we === 1'b1) begin
      wr_addr.push_back(bus.ram_address);
      wr_data.push_back(bus.ram_wdata);
    end
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && error === 1'b1) overlap_cnt++;
  end

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
  endtask

  task automatic send_frame();
    foreach (frame[i]) send(frame[i]);
    bus.rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (3) tick();
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rx_ready: got %b want 0", bus.rx_ready); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", bus.ram_we); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", error); end
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 0", hold_cpu); end
    vectors++; if (bus.ram_address !== 10'h000) begin miscompares++; $display("FAIL reset_addr: got %h want 000", bus.ram_address); end
    vectors++; if (bus.ram_wdata !== 16'h0000) begin miscompares++; $display("FAIL reset_wdata: got %h want 0000", bus.ram_wdata); end
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    vectors++; if (bus.rx_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", bus.rx_ready); end
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL hold_after_reset: got %b want 0", hold_cpu); end
    clear_log();
  endtask

  task automatic test_basic_frame();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    frame.push_back(8'h40);
`endif
    send_frame();
`ifndef LOADER_CHECKSUM_EN
    vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL basic_final_we: got %b want 1", bus.ram_we); end
`endif
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done: got %b want 1", done); end
    vectors++; if (hold_cpu !== 1'b1) begin miscompares++; $display("FAIL basic_hold_last: got %b want 1", hold_cpu); end
    idle(1);
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL basic_hold_release: got %b want 0", hold_cpu); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_single: got %b want 0", done); end
    idle(2);
    vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL basic_nwrites: got %0d want 2", wr_addr.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 10'h010 || wr_data[0] !== 16'h1234) begin miscompares++; $display("FAIL basic_w0: got %h@%h want 1234@010", wr_data[0], wr_addr[0]); end
      vectors++; if (wr_addr[1] !== 10'h011 || wr_data[1] !== 16'hABCD) begin miscompares++; $display("FAIL basic_w1: got %h@%h want abcd@011", wr_data[1], wr_addr[1]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_garbage_and_sync_data();
    clear_log();
    frame = '{8'h00, 8'hFF, 8'h5A};
    send_frame();
    idle(1);
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL garbage_hold: got %b want 0", hold_cpu); end
    frame = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h5A, 8'hA5};
`ifdef LOADER_CHECKSUM_EN
    frame.push_back(8'hFF);
`endif
    send_frame();
    idle(2);
    vectors++; if (wr_addr.size() !== 1) begin miscompares++; $display("FAIL garbage_nwrites: got %0d want 1", wr_addr.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 10'h020 || wr_data[0] !== 16'h5AA5) begin miscompares++; $display("FAIL garbage_w0: got %h@%h want 5aa5@020", wr_data[0], wr_addr[0]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL garbage_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    clear_log();
    frame = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
`ifdef LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    send_frame();
    idle(2);
    vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL wrap_nwrites: got %0d want 2", wr_addr.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 10'h3FF || wr_data[0] !== 16'h1111) begin miscompares++; $display("FAIL wrap_w0: got %h@%h want 1111@3ff", wr_data[0], wr_addr[0]); end
      vectors++; if (wr_addr[1] !== 10'h000 || wr_data[1] !== 16'h2222) begin miscompares++; $display("FAIL wrap_w1: got %h@%h want 2222@000", wr_data[1], wr_addr[1]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_gaps();
    clear_log();
    send(8'hA5); idle(1);
    send(8'h00); send(8'h50); idle(2);
    send(8'h00); send(8'h01); idle(1);
    send(8'hBE); idle(3);
    vectors++; if (hold_cpu !== 1'b1) begin miscompares++; $display("FAIL gaps_hold_mid: got %b want 1", hold_cpu); end
    send(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    idle(1);
    send(8'h51);
`endif
    idle(2);
    vectors++; if (wr_addr.size() !== 1) begin miscompares++; $display("FAIL gaps_nwrites: got %0d want 1", wr_addr.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 10'h050 || wr_data[0] !== 16'hBEEF) begin miscompares++; $display("FAIL gaps_w0: got %h@%h want beef@050", wr_data[0], wr_addr[0]); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL gaps_done_count: got %0d want 1", done_cnt); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
    send_frame();
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL badsum_error: got %b want 1", error); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL badsum_done: got %b want 0", done); end
    idle(2);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL badsum_sticky: got %b want 1", error); end
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL badsum_hold: got %b want 0", hold_cpu); end
    vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL badsum_nwrites: got %0d want 2", wr_addr.size()); end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL badsum_done_count: got %0d want 0", done_cnt); end
    send(8'hA5);
    bus.rx_valid = 1'b0;
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL badsum_clear: got %b want 0", error); end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask
`endif

  task automatic test_reset_mid_frame();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h03, 8'h01, 8'h02};
    send_frame();
    vectors++; if (bus.ram_we !== 1'b1) begin miscompares++; $display("FAIL midrst_first_we: got %b want 1", bus.ram_we); end
    reset = 1'b1;
    bus.rx_data  = 8'h03;
    bus.rx_valid = 1'b1;
    tick();
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL midrst_we_cleared: got %b want 0", bus.ram_we); end
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL midrst_hold: got %b want 0", hold_cpu); end
    reset = 1'b0;
    send(8'h04); send(8'h05);
    idle(3);
    vectors++; if (wr_addr.size() !== 1) begin miscompares++; $display("FAIL midrst_nwrites: got %0d want 1", wr_addr.size()); end
    else begin
      vectors++; if (wr_addr[0] !== 10'h030 || wr_data[0] !== 16'h0102) begin miscompares++; $display("FAIL midrst_w0: got %h@%h want 0102@030", wr_data[0], wr_addr[0]); end
    end
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_hold: got %b want 0", hold_cpu); end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL midrst_done_count: got %0d want 0", done_cnt); end
  endtask

  task automatic test_count_zero();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    send_frame();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", done); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("FAIL zero_we: got %b want 0", bus.ram_we); end
    idle(1);
    vectors++; if (hold_cpu !== 1'b0) begin miscompares++; $display("FAIL zero_hold: got %b want 0", hold_cpu); end
    idle(1);
    vectors++; if (wr_addr.size() !== 0) begin miscompares++; $display("FAIL zero_nwrites: got %0d want 0", wr_addr.size()); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_exclusive_flags();
    vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL done_error_overlap: got %0d want 0", overlap_cnt); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL final_error: got %b want 0", error); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic_frame();
    test_garbage_and_sync_data();
    test_wrap();
    test_gaps();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_reset_mid_frame();
    test_count_zero();
    test_exclusive_flags();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
